// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads one 16-bit word at PC, presents it on the shared bus and strobes the IR.
// Build option FETCH_TIMEOUT_EN adds a WAIT-state timeout that aborts the fetch and raises error.
module instruction_fetch #(
  parameter int unsigned               ADDR_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0]     RESET_PC       = '0,
  parameter int unsigned               TIMEOUT_CYCLES = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pcLoad,
  input  logic [ADDR_WIDTH-1:0] pcIn,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memRead,
  input  logic                  memReady,
  input  logic [15:0]           memData,
  inout  wire  [15:0]           data,
  output logic                  busEnable,
  output logic                  notLoad,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WAIT  = 3'd2,
    S_SETUP = 3'd3,
    S_LOAD  = 3'd4,
    S_HOLD  = 3'd5
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [15:0]             word_q;
  logic                    mem_read_q;
  logic                    bus_en_q;
  logic                    not_load_q;
  logic                    busy_q;
  logic                    done_q;
  logic [ADDR_WIDTH-1:0]   fetch_addr_d;

  // A jump target presented together with start is fetched in the same request.
  assign fetch_addr_d = pcLoad ? pcIn : pc_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;
  logic             error_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      word_q     <= '0;
      mem_read_q <= 1'b0;
      bus_en_q   <= 1'b0;
      not_load_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pcLoad) pc_q <= pcIn;
          if (start) begin
            addr_q     <= fetch_addr_d;
            mem_read_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_ADDR;
`ifdef FETCH_TIMEOUT_EN
            error_q    <= 1'b0;
`endif
          end
        end
        S_ADDR: begin
          state_q <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        S_WAIT: begin
          if (memReady) begin
            word_q     <= memData;
            mem_read_q <= 1'b0;
            bus_en_q   <= 1'b1;
            state_q    <= S_SETUP;
          end
`ifdef FETCH_TIMEOUT_EN
          // Abort cleanly: the bus was never driven, so only the read request is dropped.
          else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mem_read_q <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
`endif
        end
        S_SETUP: begin
          not_load_q <= 1'b0;
          state_q    <= S_LOAD;
        end
        S_LOAD: begin
          not_load_q <= 1'b1;
          done_q     <= 1'b1;
          state_q    <= S_HOLD;
        end
        S_HOLD: begin
          done_q   <= 1'b0;
          bus_en_q <= 1'b0;
          busy_q   <= 1'b0;
          pc_q     <= addr_q + PC_STEP;
          state_q  <= S_IDLE;
        end
        default: begin
          mem_read_q <= 1'b0;
          bus_en_q   <= 1'b0;
          not_load_q <= 1'b1;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  assign error = error_q;
`else
  assign error = 1'b0;
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  assign pc        = pc_q;
  assign memAddr   = addr_q;
  assign memRead   = mem_read_q;
  assign busEnable = bus_en_q;
  assign notLoad   = not_load_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;
  assign data      = bus_en_q ? word_q : 16'bz;

  // The IR strobe and done must only ever occur while this unit owns the bus.
  a_strobe_on_bus: assert property (@(posedge clock) disable iff (reset) !not_load_q |-> bus_en_q);
  a_done_on_bus:   assert property (@(posedge clock) disable iff (reset) done_q |-> bus_en_q);
  a_read_busy:     assert property (@(posedge clock) disable iff (reset) mem_read_q |-> busy_q);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory responder with programmable delay, IR model and bus monitor.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        pcLoad;
  logic [15:0] pcIn;
  logic [15:0] pc;
  logic [15:0] memAddr;
  logic        memRead;
  logic        memReady;
  logic [15:0] memData;
  wire  [15:0] data;
  logic        busEnable;
  logic        notLoad;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // memory responder
  int          ready_delay = 0;
  int          rd_cnt = 0;
  logic [15:0] mem_word = 16'h0000;

  // monitor state
  logic [15:0] ir = 16'h0000;
  int          nl_low = 0;
  int          contention = 0;
  int          done_cnt = 0;
  int          addr_changes = 0;
  logic [15:0] first_addr = 16'h0000;
  logic        rd_prev = 1'b0;

  int          lat;
  int          guard;
  logic [15:0] pc_before;

  instruction_fetch #(
    .ADDR_WIDTH    (16),
    .RESET_PC      (16'h0000),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .pcLoad   (pcLoad),
    .pcIn     (pcIn),
    .pc       (pc),
    .memAddr  (memAddr),
    .memRead  (memRead),
    .memReady (memReady),
    .memData  (memData),
    .data     (data),
    .busEnable(busEnable),
    .notLoad  (notLoad),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rd_cnt <= memRead ? rd_cnt + 1 : 0;
  assign memReady = memRead && (rd_cnt > ready_delay);
  // Garbage on memData when not ready shows the word is only sampled with memReady.
  assign memData  = memReady ? mem_word : ~mem_word;

  always @(posedge clock) if (!notLoad) ir <= data;

  always @(negedge clock) begin
    if (!notLoad) nl_low++;
    if (!notLoad && !busEnable) contention++;
    if (done) done_cnt++;
    if (memRead) begin
      if (!rd_prev) first_addr = memAddr;
      else if (memAddr != first_addr) addr_changes++;
    end
    rd_prev = memRead;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic clear_mon();
    nl_low = 0;
    contention = 0;
    done_cnt = 0;
    addr_changes = 0;
  endtask

  // Issues one start and returns in the cycle where done is visible; lat counts edges from the start edge.
  task automatic run_fetch(input logic ld, input logic [15:0] tgt, input int delay,
                           input logic noise, output int lat_o);
    ready_delay = delay;
    pcLoad = ld;
    pcIn   = tgt;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    pcLoad = 1'b0;
    lat_o  = 1;
    while (!done && lat_o < 40) begin
      pcLoad = noise;
      start  = noise;
      pcIn   = 16'h1234;
      tick();
      lat_o++;
    end
    start  = 1'b0;
    pcLoad = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; pcLoad = 1'b0; pcIn = 16'h0000;
    tick();
    tick();
    reset = 1'b0;

    check_eq("reset_pc",        32'(pc), 32'h0);
    check_eq("reset_busy",      32'(busy), 32'h0);
    check_eq("reset_done",      32'(done), 32'h0);
    check_eq("reset_notload",   32'(notLoad), 32'h1);
    check_eq("reset_busen",     32'(busEnable), 32'h0);
    check_eq("reset_memread",   32'(memRead), 32'h0);
    check_eq("reset_error",     32'(error), 32'h0);

    // basic fetch, memory ready in first WAIT cycle
    clear_mon();
    mem_word = 16'b1010111_101_110_011;
    run_fetch(1'b0, 16'h0000, 0, 1'b0, lat);
    check_eq("basic_latency", 32'(lat), 32'd5);
    check_eq("basic_addr",    32'(first_addr), 32'h0000);
    check_eq("basic_busen_hold", 32'(busEnable), 32'h1);
    tick();
    check_eq("basic_opcode",  32'(ir[15:9]), 32'b1010111);
    check_eq("basic_op0",     32'(ir[8:6]), 32'b101);
    check_eq("basic_op1",     32'(ir[5:3]), 32'b110);
    check_eq("basic_op2",     32'(ir[2:0]), 32'b011);
    check_eq("basic_pc",      32'(pc), 32'h1);
    check_eq("basic_bus_released", 32'(busEnable), 32'h0);
    check_eq("basic_busy_idle",    32'(busy), 32'h0);
    check_eq("basic_strobes",      32'(nl_low), 32'd1);

    // three extra wait states
    clear_mon();
    mem_word = 16'hBEEF;
    run_fetch(1'b0, 16'h0000, 3, 1'b0, lat);
    check_eq("wait_latency", 32'(lat), 32'd8);
    tick();
    check_eq("wait_addr_stable", 32'(addr_changes), 32'd0);
    check_eq("wait_addr",        32'(first_addr), 32'h0001);
    check_eq("wait_strobes",     32'(nl_low), 32'd1);
    check_eq("wait_ir",          32'(ir), 32'hBEEF);
    check_eq("wait_pc",          32'(pc), 32'h2);

    // jump with start in the same cycle; pcLoad/start noise during the fetch is ignored
    clear_mon();
    mem_word = 16'h5A5A;
    run_fetch(1'b1, 16'h0040, 2, 1'b1, lat);
    check_eq("jump_latency", 32'(lat), 32'd7);
    tick();
    check_eq("jump_addr",   32'(first_addr), 32'h0040);
    check_eq("jump_pc",     32'(pc), 32'h0041);
    check_eq("jump_ir",     32'(ir), 32'h5A5A);
    check_eq("jump_busy",   32'(busy), 32'h0);

    // PC wrap
    pcLoad = 1'b1; pcIn = 16'hFFFF;
    tick();
    pcLoad = 1'b0;
    check_eq("wrap_load_pc", 32'(pc), 32'hFFFF);
    clear_mon();
    mem_word = 16'h1357;
    run_fetch(1'b0, 16'h0000, 0, 1'b0, lat);
    tick();
    check_eq("wrap_addr", 32'(first_addr), 32'hFFFF);
    check_eq("wrap_pc",   32'(pc), 32'h0000);

    // start held high: two fetches in 12 edges, one IDLE cycle between them
    clear_mon();
    ready_delay = 0;
    start = 1'b1;
    repeat (12) tick();
    start = 1'b0;
    check_eq("b2b_done_count", 32'(done_cnt), 32'd2);
    check_eq("b2b_strobes",    32'(nl_low), 32'd2);
    check_eq("b2b_pc",         32'(pc), 32'h2);
    check_eq("b2b_contention", 32'(contention), 32'd0);

    // reset asserted while the IR strobe is low
    clear_mon();
    ready_delay = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (notLoad && guard < 20) begin
      tick();
      guard++;
    end
    check_eq("rst_mid_reached_load", 32'(notLoad), 32'h0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_eq("rst_mid_busen",   32'(busEnable), 32'h0);
    check_eq("rst_mid_notload", 32'(notLoad), 32'h1);
    check_eq("rst_mid_pc",      32'(pc), 32'h0);
    check_eq("rst_mid_done",    32'(done), 32'h0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check_eq("rst_mid_no_done", 32'(done_cnt), 32'd0);

    // memory never answers
    pcLoad = 1'b1; pcIn = 16'h0123;
    tick();
    pcLoad = 1'b0;
    pc_before = pc;
    clear_mon();
    ready_delay = 1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (25) tick();
    check_eq("stall_strobes", 32'(nl_low), 32'd0);
    check_eq("stall_pc",      32'(pc), 32'(pc_before));
`ifdef FETCH_TIMEOUT_EN
    check_eq("timeout_error",   32'(error), 32'h1);
    check_eq("timeout_busy",    32'(busy), 32'h0);
    check_eq("timeout_busen",   32'(busEnable), 32'h0);
    check_eq("timeout_no_done", 32'(done_cnt), 32'd0);
    ready_delay = 0;
    mem_word = 16'h0F0F;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("timeout_cleared", 32'(error), 32'h0);
    repeat (5) tick();
    check_eq("timeout_refetch_pc", 32'(pc), 32'h0124);
    check_eq("timeout_refetch_ir", 32'(ir), 32'h0F0F);
`else
    check_eq("stall_busy",    32'(busy), 32'h1);
    check_eq("stall_memread", 32'(memRead), 32'h1);
    check_eq("stall_error",   32'(error), 32'h0);
    check_eq("stall_addr",    32'(memAddr), 32'h0123);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("stall_recover_busy", 32'(busy), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
